// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader
// ----------------------------------------------------------------------------
// Writer side of the instruction memory. It accepts a framed byte stream over
// a valid/ready handshake and writes 16-bit instruction words into the
// instruction memory. While the image is being loaded, the CPU is kept stalled
// through cpu_hold. When the optional checksum is enabled, the CPU also stays
// stalled until the image has been verified.
//
// Frame: 0xA5, N, {hi, lo} x N [, checksum]
//
// Optional feature (compile-time macro):
//   IMEM_LOADER_CSUM_EN : adds a trailing checksum byte. The checksum is the
//                         XOR of all 2N data bytes. A mismatch sends the
//                         loader to the error state and the CPU stays held.
//
// Parameters:
//   DEPTH : number of instruction words; largest legal word count N
//   AW    : width of mem_addr / words_loaded
//
// Ports:
//   Clk          in   system clock, rising edge
//   Reset        in   synchronous, active-high reset
//   in_data      in   [7:0] stream byte
//   in_valid     in   in_data valid this cycle
//   in_ready     out  loader accepts a byte this cycle
//   reload       in   pulse; restarts a load from DONE or ERR
//   mem_we       out  instruction-memory write strobe, one cycle per word
//   mem_addr     out  [AW-1:0] write address
//   mem_wdata    out  [15:0] write data
//   cpu_hold     out  keeps the CPU stalled (PC held at 0)
//   done         out  image loaded and accepted
//   error        out  frame rejected
//   words_loaded out  [AW-1:0] words written in the current frame
// ============================================================================
module imem_loader #(
    parameter int DEPTH = 16,
    parameter int AW    = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          reload,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    output logic          cpu_hold,
    output logic          done,
    output logic          error,
    output logic [AW-1:0] words_loaded
);

    localparam logic [7:0] MAGIC = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
`ifdef IMEM_LOADER_CSUM_EN
        S_CSUM  = 3'd4,
`endif
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [15:0]   r_mem_wdata;
    logic [AW-1:0] r_words_loaded;
    logic [7:0]    r_count;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]    r_acc;
`endif

    logic          w_accept;
    logic          w_last_word;
    logic          w_count_bad;

    // The handshake only depends on the state, so a byte that arrives
    // together with reload in DONE or ERR is never consumed.
    assign in_ready = (r_state != S_DONE) && (r_state != S_ERR);
    assign w_accept = in_valid && in_ready;

    // words_loaded is bumped only after the previous strobe. By the time the
    // low byte of word k is accepted, it therefore holds k-1.
    assign w_last_word = (r_words_loaded == (AW'(r_count) - AW'(1)));
    assign w_count_bad = (in_data == 8'd0) || (int'(in_data) > DEPTH);

    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign words_loaded = r_words_loaded;
    assign done         = (r_state == S_DONE);
    assign error        = (r_state == S_ERR);
    assign cpu_hold     = (r_state != S_DONE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (in_data == MAGIC)) begin
                    w_next_state = S_COUNT;
                end
            end
            S_COUNT: begin
                if (w_accept) begin
                    w_next_state = w_count_bad ? S_ERR : S_HI;
                end
            end
            S_HI: begin
                if (w_accept) begin
                    w_next_state = S_LO;
                end
            end
            S_LO: begin
                if (w_accept) begin
`ifdef IMEM_LOADER_CSUM_EN
                    w_next_state = w_last_word ? S_CSUM : S_HI;
`else
                    w_next_state = w_last_word ? S_DONE : S_HI;
`endif
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            S_CSUM: begin
                if (w_accept) begin
                    w_next_state = (in_data == r_acc) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE, S_ERR: begin
                if (reload) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_words_loaded <= '0;
            r_count        <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            r_acc          <= '0;
`endif
        end else begin
            r_mem_we <= 1'b0;

            // The address and count advance on the cycle after the strobe,
            // so mem_addr equals the pre-increment count while mem_we is high.
            if (r_mem_we) begin
                r_words_loaded <= r_words_loaded + AW'(1);
                r_mem_addr     <= r_mem_addr + AW'(1);
            end

            if (w_accept) begin
                case (r_state)
                    S_IDLE: begin
                        if (in_data == MAGIC) begin
                            r_words_loaded <= '0;
                            r_mem_addr     <= '0;
`ifdef IMEM_LOADER_CSUM_EN
                            r_acc          <= '0;
`endif
                        end
                    end
                    S_COUNT: begin
                        r_count <= in_data;
                    end
                    S_HI: begin
                        r_mem_wdata[15:8] <= in_data;
`ifdef IMEM_LOADER_CSUM_EN
                        r_acc             <= r_acc ^ in_data;
`endif
                    end
                    S_LO: begin
                        r_mem_wdata[7:0] <= in_data;
                        r_mem_we         <= 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
                        r_acc            <= r_acc ^ in_data;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// ============================================================================
// tb_imem_loader
// ----------------------------------------------------------------------------
// Directed testbench for imem_loader. The frames follow the build: when
// IMEM_LOADER_CSUM_EN is defined, a checksum byte is appended.
// ============================================================================
module tb_imem_loader;

    localparam int AW = 16;

    logic          Clk;
    logic          Reset;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          reload;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;
    logic [AW-1:0] words_loaded;

    int n_tests;
    int n_fail;
    int n_accepted;

    logic [AW-1:0] wr_addr[$];
    logic [15:0]   wr_data[$];

    imem_loader #(.DEPTH(16), .AW(AW)) u_dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .reload       (reload),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Inputs change only #1 after a rising edge, so the negative edge sees
    // exactly the values that the next rising edge will act on.
    always @(negedge Clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
        if (in_valid && in_ready) n_accepted++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Present a byte and hold it until it has been consumed. in_valid is
    // left high so that consecutive calls stream bytes back-to-back.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            tick(1);
            n++;
        end
        if (!in_ready) begin
            check("ready_timeout", 32'(in_ready), 32'd1);
        end else begin
            tick(1);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        tick(n);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick(1);
        reload = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_we"},    32'(mem_we),       32'd0);
        check({pfx, "_addr"},  32'(mem_addr),     32'd0);
        check({pfx, "_wdata"}, 32'(mem_wdata),    32'd0);
        check({pfx, "_hold"},  32'(cpu_hold),     32'd1);
        check({pfx, "_done"},  32'(done),         32'd0);
        check({pfx, "_err"},   32'(error),        32'd0);
        check({pfx, "_words"}, 32'(words_loaded), 32'd0);
        check({pfx, "_ready"}, 32'(in_ready),     32'd1);
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        n_accepted = 0;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        n_accepted = 0;
        Reset      = 1'b1;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        reload     = 1'b0;
        tick(2);
        Reset = 1'b0;

        // Reset state
        check_reset_vals("rst");

        // Two-word frame, in_valid held high
        clear_log();
        send_byte(8'hA5); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB); send_byte(8'hCD);
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(8'h40);
`endif
        idle(3);
        check("f2_nwr", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() >= 2) begin
            check("f2_a0", 32'(wr_addr[0]), 32'd0);
            check("f2_d0", 32'(wr_data[0]), 32'h1234);
            check("f2_a1", 32'(wr_addr[1]), 32'd1);
            check("f2_d1", 32'(wr_data[1]), 32'hABCD);
        end
        check("f2_done",  32'(done),         32'd1);
        check("f2_hold",  32'(cpu_hold),     32'd0);
        check("f2_words", 32'(words_loaded), 32'd2);
        check("f2_err",   32'(error),        32'd0);
        check("f2_ready", 32'(in_ready),     32'd0);

        // reload from DONE
        pulse_reload();
        check("rl_done",  32'(done),     32'd0);
        check("rl_hold",  32'(cpu_hold), 32'd1);
        check("rl_ready", 32'(in_ready), 32'd1);

`ifdef IMEM_LOADER_CSUM_EN
        // Bad checksum
        clear_log();
        send_byte(8'hA5); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB); send_byte(8'hCD);
        send_byte(8'h41);
        idle(3);
        check("cs_nwr",   32'(wr_addr.size()), 32'd2);
        check("cs_err",   32'(error),    32'd1);
        check("cs_done",  32'(done),     32'd0);
        check("cs_hold",  32'(cpu_hold), 32'd1);
        check("cs_ready", 32'(in_ready), 32'd0);
        pulse_reload();
        check("cs_rl_err",   32'(error),    32'd0);
        check("cs_rl_ready", 32'(in_ready), 32'd1);
`endif

        // Junk in IDLE, then oversize count
        clear_log();
        send_byte(8'h00); send_byte(8'hFF);
        send_byte(8'hA5); send_byte(8'h11);
        idle(3);
        check("ov_err",   32'(error),          32'd1);
        check("ov_nwr",   32'(wr_addr.size()), 32'd0);
        check("ov_acc",   32'(n_accepted),     32'd4);
        check("ov_hold",  32'(cpu_hold),       32'd1);
        pulse_reload();

        // Zero count
        clear_log();
        send_byte(8'hA5); send_byte(8'h00);
        idle(3);
        check("z_err", 32'(error),          32'd1);
        check("z_nwr", 32'(wr_addr.size()), 32'd0);
        pulse_reload();
        check("z_rl_err", 32'(error), 32'd0);

        // Gaps in in_valid between bytes
        clear_log();
        send_byte(8'hA5); idle(2);
        send_byte(8'h01); idle(2);
        send_byte(8'hBE); idle(2);
        send_byte(8'hEF); idle(2);
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(8'h51); idle(2);
        check("gap_acc", 32'(n_accepted), 32'd5);
`else
        check("gap_acc", 32'(n_accepted), 32'd4);
`endif
        check("gap_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() >= 1) begin
            check("gap_a0", 32'(wr_addr[0]), 32'd0);
            check("gap_d0", 32'(wr_data[0]), 32'hBEEF);
        end
        check("gap_done", 32'(done), 32'd1);
        pulse_reload();

        // Reset one cycle after the first word of a 3-word frame is written
        clear_log();
        send_byte(8'hA5); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22);
        in_valid = 1'b0;
        check("mr_we", 32'(mem_we), 32'd1);
        tick(1);
        check("mr_words", 32'(words_loaded), 32'd1);
        do_reset();
        check_reset_vals("mr");
        clear_log();
        send_byte(8'hA5); send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h01);
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(8'h01);
`endif
        idle(3);
        check("mr2_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() >= 1) begin
            check("mr2_a0", 32'(wr_addr[0]), 32'd0);
            check("mr2_d0", 32'(wr_data[0]), 32'h0001);
        end
        check("mr2_done", 32'(done), 32'd1);

`ifndef IMEM_LOADER_CSUM_EN
        // A trailing byte after DONE is never consumed
        pulse_reload();
        clear_log();
        send_byte(8'hA5); send_byte(8'h01);
        send_byte(8'h56); send_byte(8'h78);
        in_data  = 8'h99;
        in_valid = 1'b1;
        tick(4);
        check("tr_acc",   32'(n_accepted), 32'd4);
        check("tr_ready", 32'(in_ready),   32'd0);
        check("tr_done",  32'(done),       32'd1);
        check("tr_nwr",   32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() >= 1) begin
            check("tr_a0", 32'(wr_addr[0]), 32'd0);
            check("tr_d0", 32'(wr_data[0]), 32'h5678);
        end
        in_valid = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
